bus_responder_8085: RTL and testbench

// Target side of the 8085 multiplexed bus driven by the CPU core: demuxes AD[7:0] on ALE, decodes memory/IO space,

---
 rtl/bus_responder_pkg.sv | 32 +++
 rtl/resp_sp_ram.sv | 21 ++
 rtl/bus_responder_8085.sv | 182 ++++++++++++++++++
 tb/tb_bus_responder_8085.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_responder_pkg.sv
// Shared types and constants for the 8085 bus responder.
package bus_responder_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_READ,
        ST_WRITE
    } state_t;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_RD,
        ACC_WR
    } access_t;

    localparam logic [1:0] IO_PA  = 2'd0;
    localparam logic [1:0] IO_PB  = 2'd1;
    localparam logic [1:0] IO_IN  = 2'd2;
    localparam logic [1:0] IO_SCR = 2'd3;

    // IO decode compares only the upper six bits; the low two pick the port.
    function automatic logic io_hit(input logic [5:0] addr_hi, input logic [5:0] base_hi);
        return addr_hi == base_hi;
    endfunction

endpackage

// File: rtl/resp_sp_ram.sv
// 256x8 single-port RAM with synchronous write and registered read.
module resp_sp_ram
    import bus_responder_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [7:0]        i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [256];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/bus_responder_8085.sv
// Target side of the 8085 multiplexed bus: address demux, RAM page and IO ports, READY wait states.
module bus_responder_8085
    import bus_responder_pkg::*;
#(
    parameter logic [7:0]  BASE_PAGE   = 8'h20,
    parameter logic [7:0]  IO_BASE     = 8'h40,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        haddress,
    input  logic [DATA_W-1:0] ad_in,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    input  logic              ALE,
    input  logic              IOMn,
    input  logic              RDn,
    input  logic              WRn,
    output logic              ready,
    input  logic [DATA_W-1:0] port_in,
    output logic [DATA_W-1:0] port_a,
    output logic [DATA_W-1:0] port_b,
    output logic              bus_err
);

    state_t            r_state;
    access_t           r_acc;
    logic [ADDR_W-1:0] r_addr_q;
    logic              r_iom_q;
    logic              r_sel_mem;
    logic              r_sel_io;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_wdata_q;
    logic [DATA_W-1:0] r_scratch;
    logic [DATA_W-1:0] r_port_in_s1;
    logic [DATA_W-1:0] r_port_in_s2;

    logic              w_hit_mem;
    logic              w_hit_io;
    logic              w_commit;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_ram_rdata;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_unused_addr_hi;

    assign w_unused_addr_hi = ^r_addr_q[15:8];

    // Decode, write commit (strobe release without a new ALE) and read-data mux.
    always_comb begin
        w_hit_mem = !IOMn && (haddress == BASE_PAGE);
        w_hit_io  = IOMn && io_hit(ad_in[7:2], IO_BASE[7:2]);
        w_commit  = !ALE && WRn && (r_acc == ACC_WR)
                    && ((r_state == ST_WAIT) || (r_state == ST_WRITE));
        w_ram_we  = w_commit && r_sel_mem;
        w_rd_data = w_ram_rdata;
        if (r_iom_q) begin
            case (r_addr_q[1:0])
                IO_PA:   w_rd_data = port_a;
                IO_PB:   w_rd_data = port_b;
                IO_IN:   w_rd_data = r_port_in_s2;
                default: w_rd_data = r_scratch;
            endcase
        end
    end

    resp_sp_ram u_ram (
        .i_clk   (clk),
        .i_we    (w_ram_we),
        .i_addr  (r_addr_q[7:0]),
        .i_wdata (r_wdata_q),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_acc        <= ACC_NONE;
            r_addr_q     <= '0;
            r_iom_q      <= 1'b0;
            r_sel_mem    <= 1'b0;
            r_sel_io     <= 1'b0;
            r_cnt        <= '0;
            r_wdata_q    <= '0;
            r_scratch    <= '0;
            r_port_in_s1 <= '0;
            r_port_in_s2 <= '0;
            ad_out       <= '0;
            ad_oe        <= 1'b0;
            ready        <= 1'b1;
            port_a       <= '0;
            port_b       <= '0;
            bus_err      <= 1'b0;
        end else begin
            r_port_in_s1 <= port_in;
            r_port_in_s2 <= r_port_in_s1;

            if (w_commit && r_sel_io) begin
                case (r_addr_q[1:0])
                    IO_PA:   port_a    <= r_wdata_q;
                    IO_PB:   port_b    <= r_wdata_q;
                    IO_SCR:  r_scratch <= r_wdata_q;
                    default: ;
                endcase
            end

            // ALE wins in every state: abandon the current cycle and re-decode.
            if (ALE) begin
                r_addr_q  <= {haddress, ad_in};
                r_iom_q   <= IOMn;
                r_sel_mem <= w_hit_mem;
                r_sel_io  <= w_hit_io;
                r_acc     <= ACC_NONE;
                ad_oe     <= 1'b0;
                ready     <= 1'b1;
                r_state   <= ST_ADDR;
            end else begin
                case (r_state)
                    ST_IDLE: ;
                    ST_ADDR: begin
                        if (!RDn || !WRn) begin
                            if (!(r_sel_mem || r_sel_io)) begin
                                r_state <= ST_IDLE;
                            end else if (!RDn && !WRn) begin
                                bus_err <= 1'b1;
                                r_state <= ST_IDLE;
                            end else begin
                                r_acc   <= !RDn ? ACC_RD : ACC_WR;
                                r_cnt   <= CNT_W'(WAIT_STATES);
                                ready   <= (WAIT_STATES == 0);
                                r_state <= ST_WAIT;
                                if (!WRn) begin
                                    r_wdata_q <= ad_in;
                                end
                            end
                        end
                    end
                    ST_WAIT: begin
                        if ((r_acc == ACC_RD && RDn) || (r_acc == ACC_WR && WRn)) begin
                            r_acc   <= ACC_NONE;
                            ready   <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            if (r_acc == ACC_WR) begin
                                r_wdata_q <= ad_in;
                            end
                            if (r_cnt <= CNT_W'(1)) begin
                                ready <= 1'b1;
                                if (r_acc == ACC_RD) begin
                                    ad_out  <= w_rd_data;
                                    ad_oe   <= 1'b1;
                                    r_state <= ST_READ;
                                end else begin
                                    r_state <= ST_WRITE;
                                end
                            end else begin
                                r_cnt <= r_cnt - CNT_W'(1);
                            end
                        end
                    end
                    ST_READ: begin
                        if (RDn) begin
                            ad_oe   <= 1'b0;
                            ad_out  <= '0;
                            r_acc   <= ACC_NONE;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_WRITE: begin
                        if (WRn) begin
                            r_acc   <= ACC_NONE;
                            r_state <= ST_IDLE;
                        end else begin
                            r_wdata_q <= ad_in;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_responder_8085.sv
// Directed bench: one responder with one wait state, a second with two, sharing the bus.
module tb_bus_responder_8085;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] haddress;
    logic [7:0] ad_in;
    logic       ALE;
    logic       IOMn;
    logic       RDn;
    logic       WRn;
    logic [7:0] port_in;

    logic [7:0] ad_out1, ad_out2, port_a1, port_a2, port_b1, port_b2;
    logic       ad_oe1, ad_oe2, ready1, ready2, bus_err1, bus_err2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bus_responder_8085 u_dut1 (
        .clk(clk), .rst(rst), .haddress(haddress), .ad_in(ad_in), .ad_out(ad_out1),
        .ad_oe(ad_oe1), .ALE(ALE), .IOMn(IOMn), .RDn(RDn), .WRn(WRn), .ready(ready1),
        .port_in(port_in), .port_a(port_a1), .port_b(port_b1), .bus_err(bus_err1)
    );

    bus_responder_8085 #(.WAIT_STATES(2)) u_dut2 (
        .clk(clk), .rst(rst), .haddress(haddress), .ad_in(ad_in), .ad_out(ad_out2),
        .ad_oe(ad_oe2), .ALE(ALE), .IOMn(IOMn), .RDn(RDn), .WRn(WRn), .ready(ready2),
        .port_in(port_in), .port_a(port_a2), .port_b(port_b2), .bus_err(bus_err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [7:0] hi, input logic [7:0] lo, input logic iom);
        haddress = hi;
        ad_in    = lo;
        IOMn     = iom;
        ALE      = 1'b1;
        tick();
        ALE      = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] hi, input logic [7:0] lo, input logic iom,
                             input logic [7:0] data, input int n);
        addr_phase(hi, lo, iom);
        ad_in = data;
        WRn   = 1'b0;
        for (int i = 0; i < n; i++) tick();
        WRn   = 1'b1;
        tick();
        ad_in = 8'h00;
    endtask

    // RDn held low three edges: dut1 data sampled after the 2nd, dut2 after the 3rd.
    task automatic bus_read(input logic [7:0] hi, input logic [7:0] lo, input logic iom,
                            output logic [7:0] d1, output logic oe1,
                            output logic [7:0] d2, output logic oe2);
        addr_phase(hi, lo, iom);
        RDn = 1'b0;
        tick();
        tick();
        d1  = ad_out1;
        oe1 = ad_oe1;
        tick();
        d2  = ad_out2;
        oe2 = ad_oe2;
        RDn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (ad_oe1 !== 1'b0)    begin n_errors++; $display("FAIL reset_ad_oe: got %b exp 0", ad_oe1); end
        n_checks++; if (ad_out1 !== 8'h00)  begin n_errors++; $display("FAIL reset_ad_out: got %h exp 00", ad_out1); end
        n_checks++; if (ready1 !== 1'b1)    begin n_errors++; $display("FAIL reset_ready1: got %b exp 1", ready1); end
        n_checks++; if (ready2 !== 1'b1)    begin n_errors++; $display("FAIL reset_ready2: got %b exp 1", ready2); end
        n_checks++; if (port_a1 !== 8'h00)  begin n_errors++; $display("FAIL reset_port_a: got %h exp 00", port_a1); end
        n_checks++; if (port_b1 !== 8'h00)  begin n_errors++; $display("FAIL reset_port_b: got %h exp 00", port_b1); end
        n_checks++; if (bus_err1 !== 1'b0)  begin n_errors++; $display("FAIL reset_bus_err: got %b exp 0", bus_err1); end
    endtask

    task automatic test_mem_rw();
        logic [7:0] d1, d2;
        logic       oe1, oe2;
        bus_write(8'h20, 8'h10, 1'b0, 8'h5A, 2);
        bus_write(8'h20, 8'h11, 1'b0, 8'hA5, 4);
        bus_read(8'h20, 8'h10, 1'b0, d1, oe1, d2, oe2);
        n_checks++; if (oe1 !== 1'b1)  begin n_errors++; $display("FAIL mem_rd_oe1: got %b exp 1", oe1); end
        n_checks++; if (d1 !== 8'h5A)  begin n_errors++; $display("FAIL mem_rd_data1: got %h exp 5a", d1); end
        n_checks++; if (oe2 !== 1'b1)  begin n_errors++; $display("FAIL mem_rd_oe2: got %b exp 1", oe2); end
        n_checks++; if (d2 !== 8'h5A)  begin n_errors++; $display("FAIL mem_rd_data2: got %h exp 5a", d2); end
        bus_read(8'h20, 8'h11, 1'b0, d1, oe1, d2, oe2);
        n_checks++; if (d1 !== 8'hA5)  begin n_errors++; $display("FAIL mem_rd_2011_1: got %h exp a5", d1); end
        n_checks++; if (d2 !== 8'hA5)  begin n_errors++; $display("FAIL mem_rd_2011_2: got %h exp a5", d2); end
        n_checks++; if (ad_oe1 !== 1'b0) begin n_errors++; $display("FAIL mem_rd_release: got %b exp 0", ad_oe1); end
    endtask

    task automatic test_io();
        logic [7:0] d1, d2;
        logic       oe1, oe2;
        bus_write(8'h41, 8'h41, 1'b1, 8'hC3, 2);
        n_checks++; if (port_b1 !== 8'hC3) begin n_errors++; $display("FAIL io_port_b1: got %h exp c3", port_b1); end
        n_checks++; if (port_a1 !== 8'h00) begin n_errors++; $display("FAIL io_port_a1: got %h exp 00", port_a1); end
        n_checks++; if (port_b2 !== 8'hC3) begin n_errors++; $display("FAIL io_port_b2: got %h exp c3", port_b2); end
        port_in = 8'h96;
        tick(); tick(); tick();
        bus_read(8'h42, 8'h42, 1'b1, d1, oe1, d2, oe2);
        n_checks++; if (d1 !== 8'h96 || oe1 !== 1'b1) begin n_errors++; $display("FAIL io_port_in1: got %h/%b exp 96/1", d1, oe1); end
        n_checks++; if (d2 !== 8'h96) begin n_errors++; $display("FAIL io_port_in2: got %h exp 96", d2); end
        bus_write(8'h40, 8'h40, 1'b1, 8'h11, 2);
        bus_write(8'h43, 8'h43, 1'b1, 8'h77, 2);
        bus_write(8'h42, 8'h42, 1'b1, 8'hFF, 2);
        n_checks++; if (port_a1 !== 8'h11) begin n_errors++; $display("FAIL io_port_a_wr: got %h exp 11", port_a1); end
        bus_read(8'h43, 8'h43, 1'b1, d1, oe1, d2, oe2);
        n_checks++; if (d1 !== 8'h77) begin n_errors++; $display("FAIL io_scratch: got %h exp 77", d1); end
        bus_read(8'h42, 8'h42, 1'b1, d1, oe1, d2, oe2);
        n_checks++; if (d1 !== 8'h96) begin n_errors++; $display("FAIL io_in_wr_ignored: got %h exp 96", d1); end
        bus_read(8'h40, 8'h40, 1'b1, d1, oe1, d2, oe2);
        n_checks++; if (d2 !== 8'h11) begin n_errors++; $display("FAIL io_port_a_rd: got %h exp 11", d2); end
    endtask

    task automatic test_wait_states();
        addr_phase(8'h20, 8'h10, 1'b0);
        n_checks++; if (ready2 !== 1'b1) begin n_errors++; $display("FAIL ws_ready_addr: got %b exp 1", ready2); end
        RDn = 1'b0;
        tick();
        n_checks++; if (ready1 !== 1'b0 || ready2 !== 1'b0) begin n_errors++; $display("FAIL ws_ready_c0: got %b%b exp 00", ready1, ready2); end
        n_checks++; if (ad_oe2 !== 1'b0) begin n_errors++; $display("FAIL ws_oe_c0: got %b exp 0", ad_oe2); end
        tick();
        n_checks++; if (ready1 !== 1'b1 || ad_oe1 !== 1'b1) begin n_errors++; $display("FAIL ws1_done: got rdy %b oe %b exp 1 1", ready1, ad_oe1); end
        n_checks++; if (ready2 !== 1'b0 || ad_oe2 !== 1'b0) begin n_errors++; $display("FAIL ws2_c1: got rdy %b oe %b exp 0 0", ready2, ad_oe2); end
        tick();
        n_checks++; if (ready2 !== 1'b1 || ad_oe2 !== 1'b1) begin n_errors++; $display("FAIL ws2_done: got rdy %b oe %b exp 1 1", ready2, ad_oe2); end
        n_checks++; if (ad_out2 !== 8'h5A) begin n_errors++; $display("FAIL ws2_data: got %h exp 5a", ad_out2); end
        RDn = 1'b1;
        tick();
        n_checks++; if (ad_oe1 !== 1'b0 || ad_oe2 !== 1'b0) begin n_errors++; $display("FAIL ws_release: got %b%b exp 00", ad_oe1, ad_oe2); end
        // Read strobe dropped while dut2 is still waiting: it must never drive.
        addr_phase(8'h20, 8'h10, 1'b0);
        RDn = 1'b0;
        tick();
        RDn = 1'b1;
        tick();
        tick();
        n_checks++; if (ad_oe2 !== 1'b0 || ready2 !== 1'b1) begin n_errors++; $display("FAIL ws_short_rd: got oe %b rdy %b exp 0 1", ad_oe2, ready2); end
    endtask

    task automatic test_miss();
        logic [7:0] d1, d2;
        logic       oe1, oe2;
        addr_phase(8'h30, 8'h10, 1'b0);
        ad_in = 8'hEE;
        WRn   = 1'b0;
        tick();
        n_checks++; if (ready1 !== 1'b1 || ready2 !== 1'b1) begin n_errors++; $display("FAIL miss_ready: got %b%b exp 11", ready1, ready2); end
        tick();
        WRn = 1'b1;
        tick();
        bus_write(8'h50, 8'h50, 1'b1, 8'hEE, 2);
        n_checks++; if (port_a1 !== 8'h11 || port_b1 !== 8'hC3) begin n_errors++; $display("FAIL miss_io_ports: got %h %h exp 11 c3", port_a1, port_b1); end
        bus_read(8'h30, 8'h10, 1'b0, d1, oe1, d2, oe2);
        n_checks++; if (oe1 !== 1'b0 || oe2 !== 1'b0) begin n_errors++; $display("FAIL miss_mem_oe: got %b%b exp 00", oe1, oe2); end
        bus_read(8'h50, 8'h50, 1'b1, d1, oe1, d2, oe2);
        n_checks++; if (oe1 !== 1'b0 || oe2 !== 1'b0) begin n_errors++; $display("FAIL miss_io_oe: got %b%b exp 00", oe1, oe2); end
        bus_read(8'h20, 8'h10, 1'b0, d1, oe1, d2, oe2);
        n_checks++; if (d1 !== 8'h5A) begin n_errors++; $display("FAIL miss_ram_kept: got %h exp 5a", d1); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1, d2;
        logic       oe1, oe2;
        bus_write(8'h20, 8'h20, 1'b0, 8'h11, 2);
        bus_write(8'h20, 8'h20, 1'b0, 8'h3C, 2);
        bus_read(8'h20, 8'h20, 1'b0, d1, oe1, d2, oe2);
        n_checks++; if (d1 !== 8'h3C) begin n_errors++; $display("FAIL b2b_rd1: got %h exp 3c", d1); end
        n_checks++; if (d2 !== 8'h3C) begin n_errors++; $display("FAIL b2b_rd2: got %h exp 3c", d2); end
    endtask

    task automatic test_error_abort();
        logic [7:0] d1, d2;
        logic       oe1, oe2;
        addr_phase(8'h20, 8'h10, 1'b0);
        RDn = 1'b0;
        WRn = 1'b0;
        tick();
        RDn = 1'b1;
        WRn = 1'b1;
        tick();
        n_checks++; if (bus_err1 !== 1'b1 || bus_err2 !== 1'b1) begin n_errors++; $display("FAIL err_set: got %b%b exp 11", bus_err1, bus_err2); end
        n_checks++; if (ad_oe1 !== 1'b0) begin n_errors++; $display("FAIL err_no_drive: got %b exp 0", ad_oe1); end
        bus_read(8'h20, 8'h10, 1'b0, d1, oe1, d2, oe2);
        n_checks++; if (bus_err1 !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got %b exp 1", bus_err1); end
        // Reset while both responders hold a pending write to 0x2010.
        addr_phase(8'h20, 8'h10, 1'b0);
        ad_in = 8'h99;
        WRn   = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        WRn = 1'b1;
        tick();
        n_checks++; if (bus_err1 !== 1'b0) begin n_errors++; $display("FAIL err_cleared: got %b exp 0", bus_err1); end
        n_checks++; if (port_b1 !== 8'h00) begin n_errors++; $display("FAIL rst_port_b: got %h exp 00", port_b1); end
        bus_read(8'h20, 8'h10, 1'b0, d1, oe1, d2, oe2);
        n_checks++; if (d1 !== 8'h5A) begin n_errors++; $display("FAIL rst_wr_dropped1: got %h exp 5a", d1); end
        n_checks++; if (d2 !== 8'h5A) begin n_errors++; $display("FAIL rst_wr_dropped2: got %h exp 5a", d2); end
    endtask

    initial begin
        rst      = 1'b1;
        haddress = 8'h00;
        ad_in    = 8'h00;
        ALE      = 1'b0;
        IOMn     = 1'b0;
        RDn      = 1'b1;
        WRn      = 1'b1;
        port_in  = 8'h00;
        test_reset();
        test_mem_rw();
        test_io();
        test_wait_states();
        test_miss();
        test_back_to_back();
        test_error_abort();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
